// File: rtl/meduram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : meduram_pkg
// Description : Shared constants, bank index type and select-width helper
//               for the multi-bank memory blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package meduram_pkg;

    localparam int C_DEFAULT_CNT_WIDTH  = 16;
    localparam int C_DEFAULT_NB_WRAGENT = 2;

    // Bank index width: one bit minimum so a single-bank build still has a port.
    function automatic int sel_width(input int nb_agent);
        return (nb_agent > 1) ? $clog2(nb_agent) : 1;
    endfunction

    typedef logic [sel_width(C_DEFAULT_NB_WRAGENT)-1:0] bank_idx_t;

endpackage
`default_nettype wire

// File: rtl/bank_accounter_if.sv
`default_nettype none
// ============================================================================
// Module      : bank_accounter_if
// Description : Write/read/collision bundle between agents and bank_accounter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bank_accounter_if
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int NB_WRAGENT   = 2,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = sel_width(NB_WRAGENT),
    parameter int CNT_WIDTH    = C_DEFAULT_CNT_WIDTH
);
    logic [NB_WRAGENT-1:0]              wren;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr;
    logic [NB_RDAGENT-1:0]              rden;
    logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr;
    logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect;
    logic                               clear;
    logic                               collision;
    logic [CNT_WIDTH-1:0]               collision_cnt;

    modport master (
        output wren, wraddr, rden, rdaddr, clear,
        input  rdselect, collision, collision_cnt
    );

    modport slave (
        input  wren, wraddr, rden, rdaddr, clear,
        output rdselect, collision, collision_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bank_accounter_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : accounter_wr_arbiter
// Description : Masks lower-index writers sharing an address with a higher
//               one and flags any same-address write collision.
// Revision    : 1.0 - initial release
// ============================================================================
module accounter_wr_arbiter
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NB_WRAGENT = 2
) (
    input  wire logic [NB_WRAGENT-1:0]            i_wren,
    input  wire logic [NB_WRAGENT*ADDR_WIDTH-1:0] i_wraddr,
    output logic      [NB_WRAGENT-1:0]            o_wr_eff,
    output logic                                  o_collision
);

    always_comb begin
        o_wr_eff    = i_wren;
        o_collision = 1'b0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            for (int j = i + 1; j < NB_WRAGENT; j++) begin
                if (i_wren[i] && i_wren[j] &&
                    (i_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == i_wraddr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    o_wr_eff[i] = 1'b0;
                    o_collision = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bank_accounter.sv
`default_nettype none
// ============================================================================
// Module      : bank_accounter
// Description : Flop-based live-value table: last writing bank per address,
//               looked up combinationally for each read agent.
//               Optional macro BANK_ACCOUNTER_COLLISION_EN builds the sticky
//               collision flag and saturating collision counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_accounter
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int NB_WRAGENT   = 2,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = sel_width(NB_WRAGENT),
    parameter int CNT_WIDTH    = C_DEFAULT_CNT_WIDTH
) (
    input wire logic        aclk,
    input wire logic        aresetn,
    bank_accounter_if.slave bus
);

    localparam int C_DEPTH = 2**ADDR_WIDTH;

    logic [SELECT_WIDTH-1:0]            r_table [C_DEPTH];
    logic [NB_WRAGENT-1:0]              w_wr_eff;
    logic                               w_collision;
    logic [NB_RDAGENT*SELECT_WIDTH-1:0] w_rdselect;

    accounter_wr_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_WRAGENT (NB_WRAGENT)
    ) u_wr_arbiter (
        .i_wren      (bus.wren),
        .i_wraddr    (bus.wraddr),
        .o_wr_eff    (w_wr_eff),
        .o_collision (w_collision)
    );

    // Writes are applied after the clear so a same-cycle write wins.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int e = 0; e < C_DEPTH; e++) begin
                r_table[e] <= '0;
            end
        end else begin
            if (bus.clear) begin
                for (int e = 0; e < C_DEPTH; e++) begin
                    r_table[e] <= '0;
                end
            end
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (w_wr_eff[i]) begin
                    r_table[bus.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= SELECT_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        w_rdselect = '0;
        for (int j = 0; j < NB_RDAGENT; j++) begin
            if (bus.rden[j]) begin
                w_rdselect[j*SELECT_WIDTH +: SELECT_WIDTH] = r_table[bus.rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    assign bus.rdselect = w_rdselect;

`ifdef BANK_ACCOUNTER_COLLISION_EN
    logic                 r_collision;
    logic [CNT_WIDTH-1:0] r_collision_cnt;

    // A clear coinciding with a collision restarts the count at one.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_collision     <= 1'b0;
            r_collision_cnt <= '0;
        end else if (bus.clear) begin
            r_collision     <= w_collision;
            r_collision_cnt <= CNT_WIDTH'(w_collision);
        end else if (w_collision) begin
            r_collision <= 1'b1;
            if (r_collision_cnt != '1) begin
                r_collision_cnt <= r_collision_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.collision     = r_collision;
    assign bus.collision_cnt = r_collision_cnt;
`else
    logic w_unused_collision;
    assign w_unused_collision = w_collision;
    assign bus.collision      = 1'b0;
    assign bus.collision_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: doc/bank_accounter.md
# bank_accounter

Live-value table for the multi-bank memory: records, for every address, which write agent (hence which bank) performed the most recent write, and returns that bank index to each read agent. It sits directly upstream of the read switch, supplying its per-read-agent bank selector in the same cycle as the read request. It is flop-based so lookups are combinational and updates take effect at the next clock edge.

## Interface
- ADDR_WIDTH, 8, address width; table depth is 2**ADDR_WIDTH entries
- NB_WRAGENT, 2, number of write agents / banks
- NB_RDAGENT, 2, number of read agents
- SELECT_WIDTH, max(1, $clog2(NB_WRAGENT)), bank index width per entry
- CNT_WIDTH, 16, collision counter width (used only with the collision feature)
- aclk  in  1  clock; one clock domain, all logic rising-edge
- aresetn  in  1  asynchronous active-low reset
- wren  in  NB_WRAGENT  per-agent write strobe
- wraddr  in  NB_WRAGENT*ADDR_WIDTH  per-agent write address, agent i at [i*ADDR_WIDTH+:ADDR_WIDTH]
- rden  in  NB_RDAGENT  per-agent read strobe
- rdaddr  in  NB_RDAGENT*ADDR_WIDTH  per-agent read address
- rdselect  out  NB_RDAGENT*SELECT_WIDTH  bank index for each read agent
- clear  in  1  synchronous table clear, single-cycle pulse
- collision  out  1  sticky write-collision flag
- collision_cnt  out  CNT_WIDTH  saturating collision-cycle count

## Operation
- Table: 2**ADDR_WIDTH entries of SELECT_WIDTH bits; every entry resets to 0 (bank 0).
- Update: per edge, each entry whose address matches an enabled writer loads that writer's index; if several enabled writers share an address, the highest agent index wins.
- Lookup: rdselect[j] = table[rdaddr[j]] when rden[j]=1, else 0; purely combinational, no arbitration between readers.
- Read-during-write same address, same cycle: rdselect returns the pre-write entry (old bank), matching the banks' read-old-data behaviour.
- clear=1: every entry loads 0 at the edge, except entries written in the same cycle, which load the writer index (write wins); also zeroes collision and collision_cnt.
- Collision: a cycle with at least two enabled writers on an identical address. Sets collision; collision_cnt increments by exactly 1 per such cycle regardless of the number of colliding pairs, saturating at all-ones.
- Out-of-range writer indices cannot occur; unused SELECT_WIDTH codes when NB_WRAGENT is not a power of two are never stored.

## Timing
- Reset values: table 0, rdselect 0, collision 0, collision_cnt 0.
- Write-to-lookup latency: 1 cycle (write at edge N visible on rdselect in cycle N+1).
- Lookup latency: 0 cycles; rdselect valid in the same cycle as rden/rdaddr.
- collision/collision_cnt update at the edge ending the colliding cycle; clear in the same cycle as a collision leaves collision=1, collision_cnt=1.
- Reset asserted mid-operation clears all state immediately; no write in that cycle is retained.

## Configuration
- BANK_ACCOUNTER_COLLISION_EN defined: collision detection, sticky flag and saturating counter are built.
- Undefined: collision ports still exist, tied to 0; no detection logic or counter flops.

## Structure
- Shared package meduram_pkg: select-width function (max(1, clog2)), bank index typedef, default CNT_WIDTH constant.
- One sub-module, accounter_wr_arbiter: combinational; given wren/wraddr, produces per-writer "effective" mask (loser of a same-address tie masked off) and the collision indication.
- Top level holds the table, clear logic, lookup muxes and collision registers.

## Test plan
- Reset then read address 0x10 on agent 0 -> rdselect[0]=0; rden[0]=0 -> rdselect[0]=0.
- Agent 1 writes 0x10 at cycle N -> agent 0 read 0x10 in cycle N returns 0, in N+1 returns 1.
- Agents 0 and 1 both write 0x22 in one cycle -> entry 0x22=1, collision=1, collision_cnt=1; repeat 3 cycles -> collision_cnt=4.
- Agent 1 writes 0x05, then clear with agent 0 writing 0x07 in same cycle -> entry 0x05=0, 0x07=0, entries written earlier by agent 1 read 0, counters 0.
- With CNT_WIDTH=2, five collision cycles -> collision_cnt holds 3; build without BANK_ACCOUNTER_COLLISION_EN -> collision and collision_cnt stay 0.
- Assert aresetn low mid-stream after writes to 0x30 by agent 1 -> all rdselect 0 immediately, entry 0x30 reads 0 after release.
